instr_queue_mw: RTL
===================

// Module: instr_queue_mw
// PURPOSE
// - Parametrised multi-lane instruction queue between fetch and decode: FETCH_WIDTH lanes in, ISSUE_WIDTH lanes out.
// - Circular buffer of DEPTH fetch_entry_t slots; absorbs the frontend/backend rate mismatch.
// - Returns per-lane consumption and a single replay request for the first valid lane it cannot store.
// - Sits after the fetch stage and feeds the decode stage directly.
// PARAMETERS
// - fetch_entry_t  logic  entry type: address, instruction, branch_predict.{cf,predict_address}
// - FETCH_WIDTH    2      input lanes, >=1
// - ISSUE_WIDTH    2      output lanes, >=1, <=DEPTH
// - DEPTH          8      slots; power of two, >=FETCH_WIDTH
// - CNT_W          $clog2(DEPTH+1)  occupancy width (derived, not overridable)
// PORTS
// - clk_i                in   1                     clock
// - rst_ni               in   1                     reset, asynchronous, active-low
// - flush_i              in   1                     synchronous flush (mispredict/exception)
// - valid_i              in   FETCH_WIDTH           lane valid
// - instr_i              in   FETCH_WIDTH x 32      instruction per lane
// - addr_i               in   FETCH_WIDTH x VLEN    PC per lane
// - cf_type_i            in   FETCH_WIDTH x cf_t    predicted control-flow type
// - predict_address_i    in   FETCH_WIDTH x VLEN    predicted target
// - ready_o              out  1                     free slots >= FETCH_WIDTH
// - consumed_o           out  FETCH_WIDTH           lane written this cycle
// - replay_o             out  1                     a valid lane was rejected
// - replay_addr_o        out  VLEN                  PC of first rejected lane
// - fetch_entry_o        out  ISSUE_WIDTH x entry   oldest entries, lane 0 = oldest
// - fetch_entry_valid_o  out  ISSUE_WIDTH           lane j valid iff occupancy > j
// - fetch_entry_ready_i  in   ISSUE_WIDTH           backend accepts lane j
// - count_o              out  CNT_W                 current occupancy
// BEHAVIOUR
// - Reset: rd/wr pointers 0, count 0; ready_o=1, consumed_o=0, replay_o=0, replay_addr_o=0,
//   fetch_entry_valid_o=0, count_o=0. Reset may assert mid-operation; all state is discarded.
// - Push: free = DEPTH-count (registered count, pre-pop; popped slots are not reused the same cycle).
//   Valid lanes are compacted in lane order; the first min(#valid, free) are written at wr_ptr, wr_ptr+1,...
//   consumed_o flags exactly those lanes.
// - Replay: if any valid lane is rejected, replay_o=1 and replay_addr_o=addr_i of the lowest-index
//   rejected lane; all later lanes are dropped, not consumed. Otherwise replay_o=0, replay_addr_o=0.
// - Pop: pop count k = length of the leading run j=0.. with valid&ready; a gap stops the run and
//   ready beyond it is ignored. rd_ptr += k.
// - count_next = count + pushes - k; pointers wrap modulo DEPTH (pointer width log2(DEPTH)).
// - Latency: a pushed entry appears on fetch_entry_o the following cycle (1 cycle) unless bypassed.
// - Outputs are combinational from registered state and current inputs; no input-to-state loop.
// - Full: count==DEPTH -> ready_o=0, every valid lane rejected, replay_addr_o=addr_i[first valid].
// - Empty: fetch_entry_valid_o=0 and fetch_entry_o=0 (no X on idle lanes); ready ignored.
// - Flush (has priority over push/pop): pointers and count cleared next edge; in the flush cycle
//   consumed_o=0, replay_o=0, fetch_entry_valid_o=0.
// - Simultaneous push+pop at full: push is limited to 0 free slots that cycle (all replayed).
// CONFIGURATION
// - IQ_BYPASS_EN defined: when count==0 and no flush, input lanes are presented directly on
//   fetch_entry_o in compacted order (valid same cycle). Lanes accepted by the backend (leading run)
//   are consumed but not written; remaining valid lanes are written as normal push.
// - IQ_BYPASS_EN undefined: no bypass; minimum fetch-to-issue latency is 1 cycle.
// TESTING (DEPTH=8, FETCH_WIDTH=2, ISSUE_WIDTH=2, no bypass unless stated)
// - Reset then push valid_i=2'b11 (PC 0x100,0x104), ready=0 -> consumed_o=2'b11; next cycle count_o=2,
//   valid=2'b11, lane0 PC 0x100, lane1 PC 0x104.
// - Fill to count=7, push 2'b11 (PC 0x200,0x204) -> consumed_o=2'b01, replay_o=1, replay_addr_o=0x204,
//   count_o=8, ready_o=0.
// - count=8, ready=2'b11 and push 2'b11 (PC 0x300) -> consumed_o=0, replay_addr_o=0x300; next count=6.
// - count=3, fetch_entry_ready_i=2'b10 -> no pop (gap at lane 0); ready=2'b01 -> 1 pop, count=2.
// - Pointer wrap: 20 cycles push 2/pop 2 -> order preserved, count stays constant, no replay.
// - flush_i with count=5 and valid_i=2'b11 -> consumed_o=0, replay_o=0; next cycle count_o=0.
// - IQ_BYPASS_EN, empty, push 2'b11 (0x400,0x404), ready=2'b01 -> lane0 0x400 same cycle; next count=1.

Source files
------------

// File: rtl/instr_queue_mw.sv
// =============================================================================
// Module      : instr_queue_mw (with package iq_pkg)
// Description : Multi-lane circular instruction queue between fetch and decode.
//               Optional same-cycle bypass when empty: define IQ_BYPASS_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package iq_pkg;
    localparam int VLEN = 32;

    typedef logic [2:0] cf_t;

    typedef struct packed {
        cf_t             cf;
        logic [VLEN-1:0] predict_address;
    } branch_predict_t;

    typedef struct packed {
        logic [VLEN-1:0] address;
        logic [31:0]     instruction;
        branch_predict_t branch_predict;
    } fetch_entry_t;
endpackage

module instr_queue_mw
    import iq_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic [FETCH_WIDTH-1:0]              valid_i,
    input  logic [FETCH_WIDTH-1:0][31:0]        instr_i,
    input  logic [FETCH_WIDTH-1:0][VLEN-1:0]    addr_i,
    input  cf_t  [FETCH_WIDTH-1:0]              cf_type_i,
    input  logic [FETCH_WIDTH-1:0][VLEN-1:0]    predict_address_i,
    output logic                                ready_o,
    output logic [FETCH_WIDTH-1:0]              consumed_o,
    output logic                                replay_o,
    output logic [VLEN-1:0]                     replay_addr_o,
    output fetch_entry_t [ISSUE_WIDTH-1:0]      fetch_entry_o,
    output logic [ISSUE_WIDTH-1:0]              fetch_entry_valid_o,
    input  logic [ISSUE_WIDTH-1:0]              fetch_entry_ready_i,
    output logic [CNT_W-1:0]                    count_o
);

    localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FW_CNT    = CNT_W'(FETCH_WIDTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    fetch_entry_t                        mem [DEPTH];
    logic [PTR_W-1:0]                    rd_ptr;
    logic [PTR_W-1:0]                    wr_ptr;
    logic [CNT_W-1:0]                    count;

    fetch_entry_t [FETCH_WIDTH-1:0]      in_entry;
    logic [FETCH_WIDTH-1:0][CNT_W-1:0]   rank;
    logic [CNT_W-1:0]                    num_valid;
    logic [CNT_W-1:0]                    free_slots;
    logic [CNT_W-1:0]                    pop_cnt;
    logic [CNT_W-1:0]                    deq_cnt;
    logic [CNT_W-1:0]                    byp_cnt;
    logic [CNT_W-1:0]                    push_cnt;
    logic                                bypass;
    logic                                pop_run;
    logic                                rejected;
    logic [FETCH_WIDTH-1:0]              wr_en;
    logic [FETCH_WIDTH-1:0][PTR_W-1:0]   wr_slot;

    generate
        for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_in_entry
            assign in_entry[i].address                        = addr_i[i];
            assign in_entry[i].instruction                    = instr_i[i];
            assign in_entry[i].branch_predict.cf              = cf_type_i[i];
            assign in_entry[i].branch_predict.predict_address = predict_address_i[i];
        end
    endgenerate

`ifdef IQ_BYPASS_EN
    assign bypass = (count == '0) && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    // Compaction rank: position of each valid lane among the valid lanes.
    always_comb begin
        num_valid = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            rank[i] = num_valid;
            if (valid_i[i]) begin
                num_valid = num_valid + ONE_CNT;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            fetch_entry_valid_o[j] = 1'b0;
            fetch_entry_o[j]       = '0;
            if (bypass) begin
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    if (valid_i[i] && (rank[i] == CNT_W'(j))) begin
                        fetch_entry_valid_o[j] = 1'b1;
                        fetch_entry_o[j]       = in_entry[i];
                    end
                end
            end else if (count > CNT_W'(j)) begin
                fetch_entry_valid_o[j] = !flush_i;
                fetch_entry_o[j]       = mem[rd_ptr + PTR_W'(j)];
            end
        end
    end

    // Pop only the leading run of accepted lanes; a gap ends it.
    always_comb begin
        pop_cnt = '0;
        pop_run = 1'b1;
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            if (pop_run && fetch_entry_valid_o[j] && fetch_entry_ready_i[j]) begin
                pop_cnt = pop_cnt + ONE_CNT;
            end else begin
                pop_run = 1'b0;
            end
        end
    end

    assign byp_cnt    = bypass ? pop_cnt : '0;
    assign deq_cnt    = bypass ? '0 : pop_cnt;
    assign free_slots = DEPTH_CNT - count;
    assign ready_o    = (free_slots >= FW_CNT);
    assign count_o    = count;

    // Free space uses the pre-pop count, so slots freed this cycle are not reused yet.
    always_comb begin
        consumed_o    = '0;
        rejected      = 1'b0;
        replay_addr_o = '0;
        wr_en         = '0;
        push_cnt      = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_slot[i] = wr_ptr + PTR_W'(rank[i] - byp_cnt);
            if (valid_i[i] && !flush_i) begin
                if (rank[i] < free_slots) begin
                    consumed_o[i] = 1'b1;
                    if (rank[i] >= byp_cnt) begin
                        wr_en[i] = 1'b1;
                        push_cnt = push_cnt + ONE_CNT;
                    end
                end else if (!rejected) begin
                    rejected      = 1'b1;
                    replay_addr_o = addr_i[i];
                end
            end
        end
    end

    assign replay_o = rejected;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(deq_cnt);
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            count  <= count + push_cnt - deq_cnt;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (wr_en[i]) begin
                mem[wr_slot[i]] <= in_entry[i];
            end
        end
    end

endmodule

`default_nettype wire
